// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalisation frame sequencer.
package hist_eq_pkg;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_WAIT_SOF,
        S_ACTIVE,
        S_CDF
    } state_e;

    localparam int BOUND_WIDTH = 10;

    function automatic int num_bins(input int data_width);
        return 1 << data_width;
    endfunction

endpackage

// File: rtl/hist_eq_frame_cnt.sv
// Column/row position tracking for the incoming pixel stream and last-line detection.
// Optional line-geometry check enabled by defining HIST_CTRL_GEOM_CHECK_EN.
module hist_eq_frame_cnt
    import hist_eq_pkg::*;
#(
    parameter int DIM_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnt_en,
    input  logic                 sof,
    input  logic                 tlast,
    input  logic [DIM_WIDTH-1:0] img_width,
    input  logic [DIM_WIDTH-1:0] img_height,
    output logic                 last_line,
    output logic                 err_line
);

    logic [DIM_WIDTH-1:0] col_q, col_d;
    logic [DIM_WIDTH-1:0] row_q, row_d;
    logic [DIM_WIDTH-1:0] col_base;
    logic [DIM_WIDTH-1:0] row_base;

    // A start-of-frame beat is itself pixel (0,0), so it counts from a zero base.
    always_comb begin
        col_base  = sof ? '0 : col_q;
        row_base  = sof ? '0 : row_q;
        col_d     = col_q;
        row_d     = row_q;
        if (cnt_en) begin
            if (tlast) begin
                col_d = '0;
                row_d = row_base + DIM_WIDTH'(1);
            end else begin
                col_d = col_base + DIM_WIDTH'(1);
                row_d = row_base;
            end
        end
        last_line = cnt_en & tlast & (row_base == img_height - DIM_WIDTH'(1));
    end

`ifdef HIST_CTRL_GEOM_CHECK_EN
    always_comb begin
        err_line = cnt_en & ((tlast & (col_base != img_width - DIM_WIDTH'(1))) |
                             (~tlast & (col_base == img_width - DIM_WIDTH'(1))));
    end
`else
    logic geom_unused;
    assign geom_unused = ^img_width;
    assign err_line    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/hist_eq_frame_ctrl.sv
// Frame sequencer: shadows config at SOF and cycles the ping-pong histogram banks
// through accumulate -> CDF build -> bin clear. Geometry check: HIST_CTRL_GEOM_CHECK_EN.
module hist_eq_frame_ctrl
    import hist_eq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIM_WIDTH  = 12
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_aresetn,
    input  logic [DATA_WIDTH-1:0]  contrast_threshold_param,
    input  logic [BOUND_WIDTH-1:0] upper_bound_param,
    input  logic [BOUND_WIDTH-1:0] lower_bound_param,
    input  logic                   thresholding_en,
    input  logic [DIM_WIDTH-1:0]   img_width,
    input  logic [DIM_WIDTH-1:0]   img_height,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tready,
    input  logic                   i_cdf_done,
    output logic                   o_accept_en,
    output logic [DATA_WIDTH-1:0]  o_contrast_threshold,
    output logic [BOUND_WIDTH-1:0] o_upper_bound,
    output logic [BOUND_WIDTH-1:0] o_lower_bound,
    output logic                   o_thresholding_en,
    output logic                   o_bank_sel,
    output logic                   o_cdf_start,
    output logic                   o_clr_we,
    output logic [DATA_WIDTH-1:0]  o_clr_addr,
    output logic                   o_frame_active,
    output logic                   o_frame_done,
    output logic                   o_err_sof,
    output logic                   o_err_line
);

    localparam logic [DATA_WIDTH-1:0] LAST_BIN = DATA_WIDTH'(num_bins(DATA_WIDTH) - 1);

    state_e                 state_q, state_d;
    logic                   accept_en_q, accept_en_d;
    logic [DATA_WIDTH-1:0]  thr_q, thr_d;
    logic [BOUND_WIDTH-1:0] ub_q, ub_d;
    logic [BOUND_WIDTH-1:0] lb_q, lb_d;
    logic                   th_en_q, th_en_d;
    logic                   bank_sel_q, bank_sel_d;
    logic                   cdf_start_q, cdf_start_d;
    logic                   clr_we_q, clr_we_d;
    logic [DATA_WIDTH-1:0]  clr_addr_q, clr_addr_d;
    logic                   frame_active_q, frame_active_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_sof_q, err_sof_d;
    logic                   err_line_q, err_line_d;

    logic beat, sof, cnt_en, last_line, cnt_err_line;

    assign beat   = s_axis_tvalid & s_axis_tready;
    assign sof    = beat & s_axis_tuser & ((state_q == S_WAIT_SOF) | (state_q == S_ACTIVE));
    assign cnt_en = sof | (beat & (state_q == S_ACTIVE));

    hist_eq_frame_cnt #(
        .DIM_WIDTH (DIM_WIDTH)
    ) u_frame_cnt (
        .clk        (i_sys_clk),
        .rst_n      (i_sys_aresetn),
        .cnt_en     (cnt_en),
        .sof        (sof),
        .tlast      (s_axis_tlast),
        .img_width  (img_width),
        .img_height (img_height),
        .last_line  (last_line),
        .err_line   (cnt_err_line)
    );

    always_comb begin
        state_d        = state_q;
        accept_en_d    = accept_en_q;
        thr_d          = thr_q;
        ub_d           = ub_q;
        lb_d           = lb_q;
        th_en_d        = th_en_q;
        bank_sel_d     = bank_sel_q;
        clr_we_d       = clr_we_q;
        clr_addr_d     = clr_addr_q;
        frame_active_d = frame_active_q;
        cdf_start_d    = 1'b0;
        frame_done_d   = 1'b0;
        err_sof_d      = 1'b0;
        err_line_d     = cnt_err_line;

        case (state_q)
            // First S_CLEAR cycle only raises the write strobe at bin 0.
            S_CLEAR: begin
                accept_en_d = 1'b0;
                if (clr_we_q && (clr_addr_q == LAST_BIN)) begin
                    clr_we_d    = 1'b0;
                    clr_addr_d  = '0;
                    accept_en_d = 1'b1;
                    state_d     = S_WAIT_SOF;
                end else begin
                    clr_we_d   = 1'b1;
                    clr_addr_d = clr_we_q ? clr_addr_q + DATA_WIDTH'(1) : '0;
                end
            end
            S_WAIT_SOF: begin
                if (sof) begin
                    frame_active_d = 1'b1;
                    state_d        = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                err_sof_d = sof;
            end
            S_CDF: begin
                accept_en_d = 1'b0;
                if (i_cdf_done) begin
                    bank_sel_d = ~bank_sel_q;
                    state_d    = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase

        if (sof) begin
            thr_d   = contrast_threshold_param;
            ub_d    = upper_bound_param;
            lb_d    = lower_bound_param;
            th_en_d = thresholding_en;
        end

        if (last_line) begin
            frame_done_d   = 1'b1;
            cdf_start_d    = 1'b1;
            frame_active_d = 1'b0;
            accept_en_d    = 1'b0;
            state_d        = S_CDF;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q        <= S_CLEAR;
            accept_en_q    <= 1'b0;
            thr_q          <= '0;
            ub_q           <= '0;
            lb_q           <= '0;
            th_en_q        <= 1'b0;
            bank_sel_q     <= 1'b0;
            cdf_start_q    <= 1'b0;
            clr_we_q       <= 1'b0;
            clr_addr_q     <= '0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            err_sof_q      <= 1'b0;
            err_line_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            accept_en_q    <= accept_en_d;
            thr_q          <= thr_d;
            ub_q           <= ub_d;
            lb_q           <= lb_d;
            th_en_q        <= th_en_d;
            bank_sel_q     <= bank_sel_d;
            cdf_start_q    <= cdf_start_d;
            clr_we_q       <= clr_we_d;
            clr_addr_q     <= clr_addr_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
            err_sof_q      <= err_sof_d;
            err_line_q     <= err_line_d;
        end
    end

    assign o_accept_en          = accept_en_q;
    assign o_contrast_threshold = thr_q;
    assign o_upper_bound        = ub_q;
    assign o_lower_bound        = lb_q;
    assign o_thresholding_en    = th_en_q;
    assign o_bank_sel           = bank_sel_q;
    assign o_cdf_start          = cdf_start_q;
    assign o_clr_we             = clr_we_q;
    assign o_clr_addr           = clr_addr_q;
    assign o_frame_active       = frame_active_q;
    assign o_frame_done         = frame_done_q;
    assign o_err_sof            = err_sof_q;
    assign o_err_line           = err_line_q;

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
// Randomized bench for hist_eq_frame_ctrl against a frame-level reference model.
module tb_hist_eq_frame_ctrl;

    localparam int DW   = 8;
    localparam int DIMW = 12;
    localparam int BW   = 10;
    localparam int NB   = 256;
    localparam int NCYC = 20000;
`ifdef HIST_CTRL_GEOM_CHECK_EN
    localparam bit GEOM_EN = 1'b1;
`else
    localparam bit GEOM_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   thr_p;
    logic [BW-1:0]   ub_p, lb_p;
    logic            te_p;
    logic [DIMW-1:0] img_w, img_h;
    logic            tvalid, tuser, tlast, src_rdy, tready, cdf_done;
    logic            accept_en, th_en_o, bank_sel, cdf_start, clr_we;
    logic            frame_active, frame_done, err_sof, err_line;
    logic [DW-1:0]   thr_o, clr_addr;
    logic [BW-1:0]   ub_o, lb_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    assign tready = src_rdy & accept_en;

    hist_eq_frame_ctrl #(.DATA_WIDTH(DW), .DIM_WIDTH(DIMW)) dut (
        .i_sys_clk                (clk),
        .i_sys_aresetn            (rst_n),
        .contrast_threshold_param (thr_p),
        .upper_bound_param        (ub_p),
        .lower_bound_param        (lb_p),
        .thresholding_en          (te_p),
        .img_width                (img_w),
        .img_height               (img_h),
        .s_axis_tvalid            (tvalid),
        .s_axis_tuser             (tuser),
        .s_axis_tlast             (tlast),
        .s_axis_tready            (tready),
        .i_cdf_done               (cdf_done),
        .o_accept_en              (accept_en),
        .o_contrast_threshold     (thr_o),
        .o_upper_bound            (ub_o),
        .o_lower_bound            (lb_o),
        .o_thresholding_en        (th_en_o),
        .o_bank_sel               (bank_sel),
        .o_cdf_start              (cdf_start),
        .o_clr_we                 (clr_we),
        .o_clr_addr               (clr_addr),
        .o_frame_active           (frame_active),
        .o_frame_done             (frame_done),
        .o_err_sof                (err_sof),
        .o_err_line               (err_line)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase flags plus line/column tallies of the current frame.
    bit            m_clearing, m_wait_cdf, m_in_frame;
    int            m_sweep, m_lines, m_col;
    bit            e_accept, e_active, e_done, e_cdf_start, e_err_sof, e_err_line, e_bank, e_clr_we;
    int            e_clr_addr;
    logic [DW-1:0] e_thr;
    logic [BW-1:0] e_ub, e_lb;
    bit            e_te;

    task automatic model_reset();
        m_clearing = 1; m_sweep = 0; m_wait_cdf = 0; m_in_frame = 0;
        m_lines = 0; m_col = 0;
        e_accept = 0; e_active = 0; e_done = 0; e_cdf_start = 0; e_err_sof = 0;
        e_err_line = 0; e_bank = 0; e_clr_we = 0; e_clr_addr = 0;
        e_thr = '0; e_ub = '0; e_lb = '0; e_te = 0;
    endtask

    task automatic model_step(input bit v, input bit u, input bit l, input bit rdy, input bit done,
                              input int w, input int h);
        bit beat;
        bit geom_bad;
        beat = v & rdy & e_accept;
        e_done = 0; e_cdf_start = 0; e_err_sof = 0; e_err_line = 0; e_clr_we = 0;
        if (m_clearing) begin
            if (m_sweep < NB) begin
                e_clr_we = 1; e_clr_addr = m_sweep; m_sweep++;
            end else begin
                m_clearing = 0; e_accept = 1;
            end
        end else if (m_wait_cdf) begin
            if (done) begin
                e_bank = ~e_bank; m_wait_cdf = 0; m_clearing = 1; m_sweep = 0;
            end
        end else if (beat) begin
            if (u) begin
                if (m_in_frame) e_err_sof = 1;
                e_thr = thr_p; e_ub = ub_p; e_lb = lb_p; e_te = te_p;
                m_in_frame = 1; e_active = 1; m_lines = 0; m_col = 0;
            end
            if (m_in_frame) begin
                geom_bad   = (l && m_col != w - 1) || (!l && m_col == w - 1);
                e_err_line = GEOM_EN & geom_bad;
                if (l) begin m_lines++; m_col = 0; end
                else m_col++;
                if (l && m_lines == h) begin
                    e_done = 1; e_cdf_start = 1; e_active = 0; e_accept = 0;
                    m_in_frame = 0; m_wait_cdf = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("accept_en", accept_en, e_accept);
        chk("frame_active", frame_active, e_active);
        chk("frame_done", frame_done, e_done);
        chk("cdf_start", cdf_start, e_cdf_start);
        chk("err_sof", err_sof, e_err_sof);
        chk("err_line", err_line, e_err_line);
        chk("bank_sel", bank_sel, e_bank);
        chk("clr_we", clr_we, e_clr_we);
        if (e_clr_we) chk("clr_addr", clr_addr, e_clr_addr);
        chk("threshold", thr_o, e_thr);
        chk("upper_bound", ub_o, e_ub);
        chk("lower_bound", lb_o, e_lb);
        chk("thr_en", th_en_o, e_te);
    endtask

    // Stimulus generator position inside the frame it is sending.
    int gen_col, gen_line;
    bit junk, beat_obs;
    int cur_col, cur_line;

    task automatic drive_inputs();
        bit inj;
        tvalid   = ($urandom % 4) != 0;
        src_rdy  = ($urandom % 4) != 0;
        cdf_done = ($urandom % 6) == 0;
        if ($urandom % 8 == 0) begin
            thr_p = DW'($urandom); ub_p = BW'($urandom); lb_p = BW'($urandom); te_p = 1'($urandom);
        end
        inj  = (gen_col != 0 || gen_line != 0) && ($urandom % 50 == 0);
        junk = (gen_col == 0 && gen_line == 0) && ($urandom % 5 == 0);
        cur_col  = inj ? 0 : gen_col;
        cur_line = inj ? 0 : gen_line;
        tuser = junk ? 1'b0 : (cur_col == 0 && cur_line == 0);
        tlast = junk ? 1'b0 : (cur_col >= int'(img_w) - 1);
        if ($urandom % 30 == 0) tlast = ~tlast;
        beat_obs = tvalid & src_rdy & accept_en;
    endtask

    initial begin
        bit did_reset = 0;
        rst_n = 0;
        tvalid = 0; tuser = 0; tlast = 0; src_rdy = 0; cdf_done = 0;
        thr_p = 8'h40; ub_p = 10'd100; lb_p = 10'd900; te_p = 1;
        img_w = 12'd4; img_h = 12'd3;
        gen_col = 0; gen_line = 0;
        model_reset();
        #12;
        check_outputs();
        chk("rst_clr_addr", clr_addr, 0);
        @(negedge clk);
        rst_n = 1;
        drive_inputs();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step(tvalid, tuser, tlast, src_rdy, cdf_done, int'(img_w), int'(img_h));
            #1;
            check_outputs();
            if (beat_obs && !junk) begin
                if (tlast) begin
                    gen_col  = 0;
                    gen_line = cur_line + 1;
                    if (gen_line >= int'(img_h)) gen_line = 0;
                end else begin
                    gen_col  = cur_col + 1;
                    gen_line = cur_line;
                end
            end
            if (!did_reset && cyc > 2000 && clr_we && clr_addr == 8'd100) begin
                did_reset = 1;
                rst_n = 0;
                #1;
                model_reset();
                check_outputs();
                chk("midrst_clr_addr", clr_addr, 0);
                img_w = 12'($urandom_range(1, 5));
                img_h = 12'($urandom_range(2, 4));
                gen_col = 0; gen_line = 0;
                @(negedge clk);
                rst_n = 1;
            end
            drive_inputs();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
